// File: rtl/picomips_pkg.sv
// picoMips shared types and sequencer defaults.
// Stage encoding matches the decoder's Stage convention.
package picomips_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'b00,
        DECODE  = 2'b01,
        EXECUTE = 2'b10,
        WRITE   = 2'b11
    } stage_t;

    localparam int MUL_CYCLES_DEF  = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int HOLD_W_DEF      = 8;

    // Multiply counter is sized for the full legal MUL_CYCLES range.
    localparam int MUL_CNT_W = 4;

endpackage

// File: rtl/stage_sequencer_sync.sv
// handshake_sync: STAGES-deep flop chain for an asynchronous level.
// The output is the last flop; latency is STAGES rising edges.
module handshake_sync #(
    parameter int STAGES = 2
) (
    input  logic Clock,
    input  logic Reset,
    input  logic async_i,
    output logic sync_o
);

    logic [STAGES-1:0] chain_q;

    // Shift the raw level through the chain; cleared on reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: picoMips FETCH/DECODE/EXECUTE/WRITE sequencer.
// Optional single-step gating is built with STAGE_SEQ_STEP_EN.
module stage_sequencer
    import picomips_pkg::*;
#(
    parameter int MUL_CYCLES  = MUL_CYCLES_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_W      = HOLD_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic              HandshakeIn,
    input  logic              UseMul,
    input  logic              PCHold,
`ifdef STAGE_SEQ_STEP_EN
    input  logic              Step,
`endif
    output logic [1:0]        Stage,
    output logic              Handshake,
    output logic              PCEn,
    output logic              MulBusy,
    output logic              Idle,
    output logic [HOLD_W-1:0] HoldCycles
);

    localparam bit STRETCH = (MUL_CYCLES > 1);
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD =
        MUL_CNT_W'(MUL_CYCLES - 1);

    stage_t                state_q;
    logic [MUL_CNT_W-1:0]  cnt_q;
    logic                  busy_q;
    logic                  idle_q;
    logic [HOLD_W-1:0]     hold_q;
    logic [HOLD_W-1:0]     hold_d;
    logic                  go;

    handshake_sync #(
        .STAGES (SYNC_STAGES)
    ) u_hs_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .async_i (HandshakeIn),
        .sync_o  (Handshake)
    );

`ifdef STAGE_SEQ_STEP_EN
    logic step_sync;
    logic step_prev_q;
    logic step_pend_q;
    logic step_rise;

    handshake_sync #(
        .STAGES (SYNC_STAGES)
    ) u_step_sync (
        .Clock   (Clock),
        .Reset   (Reset),
        .async_i (Step),
        .sync_o  (step_sync)
    );

    assign step_rise = step_sync && !step_prev_q;
    assign go        = Run && (step_rise || step_pend_q);

    // Edge detector history and pending flag for early Step edges.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            step_prev_q <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_prev_q <= step_sync;
            if (state_q == FETCH && go) begin
                step_pend_q <= 1'b0;
            end else if (step_rise) begin
                step_pend_q <= 1'b1;
            end
        end
    end
`else
    assign go = Run;
`endif

    // Saturating pass counter for held instructions.
    always_comb begin
        hold_d = '0;
        if (PCHold) begin
            hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        end
    end

    // Stage FSM with registered MulBusy, Idle and HoldCycles.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            idle_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (go) begin
                        state_q <= DECODE;
                        idle_q  <= 1'b0;
                    end else begin
                        idle_q  <= 1'b1;
                    end
                end
                DECODE: begin
                    state_q <= EXECUTE;
                    if (UseMul && STRETCH) begin
                        cnt_q  <= MUL_LOAD;
                        busy_q <= 1'b1;
                    end else begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                EXECUTE: begin
                    if (cnt_q == '0) begin
                        state_q <= WRITE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - 1'b1;
                        busy_q  <= (cnt_q != MUL_CNT_W'(1));
                    end
                end
                WRITE: begin
                    state_q <= FETCH;
                    hold_q  <= hold_d;
                end
            endcase
        end
    end

    assign Stage      = state_q;
    assign PCEn       = (state_q == WRITE) && !PCHold;
    assign MulBusy    = busy_q;
    assign Idle       = idle_q;
    assign HoldCycles = hold_q;

endmodule
